// File: rtl/phase_pkg.sv
// Shared definitions for the bitstream phase stage.
package phase_pkg;

  localparam int unsigned PHASE_KW = 2;

  typedef logic [PHASE_KW-1:0] phase_k_t;

endpackage

// File: rtl/phase_rotr_comb.sv
// Combinational right rotator: out_bits[i] = in_bits[(i + k) mod BITSTREAM].
module phase_rotr_comb
  import phase_pkg::*;
#(
  parameter int unsigned BITSTREAM = 64
) (
  input  phase_k_t               k,
  input  logic [BITSTREAM-1:0]   in_bits,
  output logic [BITSTREAM-1:0]   out_bits
);

  // One 4:1 mux per output bit; tap indices wrap at elaboration time.
  for (genvar i = 0; i < BITSTREAM; i++) begin : g_bit
    logic [3:0] taps;

    assign taps = {in_bits[(i + 3) % BITSTREAM],
                   in_bits[(i + 2) % BITSTREAM],
                   in_bits[(i + 1) % BITSTREAM],
                   in_bits[i]};

    assign out_bits[i] = taps[k];
  end

endmodule

// File: rtl/phase_rotator_2b.sv
// Registered 2-bit phase rotator: rotates in_bits right by k, result one clock later.
module phase_rotator_2b
  import phase_pkg::*;
#(
  parameter int unsigned BITSTREAM = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [PHASE_KW-1:0]    k,
  input  logic [BITSTREAM-1:0]   in_bits,
  output logic                   out_valid,
  output logic [BITSTREAM-1:0]   out_bits
);

  logic [BITSTREAM-1:0] rot_bits;

  phase_rotr_comb #(
    .BITSTREAM (BITSTREAM)
  ) u_rotr (
    .k        (phase_k_t'(k)),
    .in_bits  (in_bits),
    .out_bits (rot_bits)
  );

  // Data only loads on valid so don't-care inputs never reach the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_bits <= rot_bits;
      end
    end
  end

endmodule

// File: tb/tb_phase_rotator_2b.sv
// Self-checking bench for phase_rotator_2b against a shift-based rotate model.
module tb_phase_rotator_2b;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   k;
  logic [W-1:0] in_bits;
  logic         out_valid;
  logic [W-1:0] out_bits;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  logic [W-1:0] exp_bits  = '0;
  logic         exp_valid = 1'b0;

  always #5 clk = ~clk;

  phase_rotator_2b #(
    .BITSTREAM (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .k         (k),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_bits  (out_bits)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rot_ref(input logic [W-1:0] x, input int unsigned s);
    if (s == 0) return x;
    return (x >> s) | (x << (W - s));
  endfunction

  // Drive one cycle, advance the model, compare both outputs after the edge.
  task automatic cycle(input logic r, input logic v, input logic [1:0] kk,
                       input logic [W-1:0] d, input string tag);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    k        = kk;
    in_bits  = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_bits  = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_bits  = rot_ref(d, int'(kk));
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    check({tag, "_valid"}, W'(out_valid), W'(exp_valid));
    check({tag, "_bits"}, out_bits, exp_bits);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [1:0]   kk;

    rst      = 1'b1;
    in_valid = 1'b0;
    k        = 2'd0;
    in_bits  = '0;

    // Reset wins over a valid all-ones word.
    cycle(1'b1, 1'b1, 2'd0, {W{1'b1}}, "rst0");
    cycle(1'b1, 1'b1, 2'd3, {W{1'b1}}, "rst1");
    cycle(1'b0, 1'b0, 2'd0, {W{1'b1}}, "post_rst");
    check("post_rst_lit", out_bits, 64'h0);

    cycle(1'b0, 1'b1, 2'd0, 64'hDEADBEEF_CAFEF00D, "k0");
    check("k0_lit", out_bits, 64'hDEADBEEF_CAFEF00D);
    cycle(1'b0, 1'b1, 2'd1, 64'h1, "wrap_k1");
    check("wrap_k1_lit", out_bits, 64'h8000_0000_0000_0000);
    cycle(1'b0, 1'b1, 2'd2, 64'h3, "wrap_k2");
    check("wrap_k2_lit", out_bits, 64'hC000_0000_0000_0000);
    cycle(1'b0, 1'b1, 2'd3, 64'hF, "wrap_k3");
    check("wrap_k3_lit", out_bits, 64'hE000_0000_0000_0001);

    // Hold: invalid cycles must not disturb out_bits, even with X inputs.
    cycle(1'b0, 1'b1, 2'd1, 64'h2, "hold_load");
    check("hold_load_lit", out_bits, 64'h1);
    cycle(1'b0, 1'b0, 2'd2, {W{1'b1}}, "hold_ones");
    check("hold_ones_lit", out_bits, 64'h1);
    cycle(1'b0, 1'b0, 2'bxx, {W{1'bx}}, "hold_x");
    check("hold_x_lit", out_bits, 64'h1);

    // Back-to-back stream, k cycling through 0..3.
    for (int q = 0; q <= 100; q++) begin
      d  = {$urandom, $urandom};
      kk = 2'(q % 4);
      cycle(1'b0, 1'b1, kk, d, "b2b");
    end

    // Stream with a one-cycle reset in the middle.
    for (int q = 0; q < 40; q++) begin
      d  = {$urandom, $urandom};
      kk = 2'($urandom_range(3, 0));
      cycle(q == 20 ? 1'b1 : 1'b0, 1'b1, kk, d, q == 20 ? "mid_rst" : "stream");
    end

    // Random valid gaps.
    for (int q = 0; q < 200; q++) begin
      d  = {$urandom, $urandom};
      kk = 2'($urandom_range(3, 0));
      cycle($urandom_range(31, 0) == 0 ? 1'b1 : 1'b0, 1'($urandom_range(1, 0)), kk, d, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
